// File: rtl/uart_frame_parser.sv
// Framed command parser behind the UART receiver: SOF, LEN, payload, XOR checksum.
// A validated payload is held until acked and read through a registered random-access port.
module uart_frame_parser #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAX_LEN = 16,
    parameter int         AW      = 4,
    parameter int         TIMEOUT = 312500
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    byte_i,
    input  logic          byte_vld_i,
    output logic          frm_valid_o,
    output logic [AW:0]   frm_len_o,
    input  logic          frm_ack_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic          ovf_o,
    output logic [2:0]    dbg_state
);

    localparam int            CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [AW:0]   MAX_LEN_A = (AW+1)'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_CHK, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   frm_len_d;
    logic          err_d, ovf_d, wr_en, active;
    logic [1:0]    err_code_d;
    logic [7:0]    pay_mem [2**AW];

    assign active      = (state_q == S_LEN) || (state_q == S_PAY) || (state_q == S_CHK);
    assign frm_valid_o = (state_q == S_HOLD);
    assign dbg_state   = state_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        cnt_d      = '0;
        frm_len_d  = frm_len_o;
        err_d      = 1'b0;
        err_code_d = err_code_o;
        ovf_d      = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (byte_vld_i && byte_i == SOF) state_d = S_LEN;
            end
            S_LEN: begin
                if (byte_vld_i) begin
                    if (byte_i == 8'h00 || byte_i > MAX_LEN_B) begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        len_d   = byte_i[AW:0];
                        chk_d   = byte_i;
                        idx_d   = '0;
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (byte_vld_i) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ byte_i;
                    idx_d = idx_q + (AW+1)'(1);
                    if (idx_q + (AW+1)'(1) == len_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (byte_vld_i) begin
                    if (byte_i == chk_q) begin
                        state_d   = S_HOLD;
                        frm_len_d = len_q;
                    end else begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
            end
            S_HOLD: begin
                // Buffer is frozen: any byte here is lost, even on the ack cycle.
                ovf_d = byte_vld_i;
                if (frm_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Inter-byte timeout; a byte on the terminal count cycle takes precedence.
        if (active && !byte_vld_i) begin
            if (cnt_q == CNT_LAST) begin
                state_d    = S_IDLE;
                err_d      = 1'b1;
                err_code_d = 2'b11;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            cnt_q      <= '0;
            frm_len_o  <= '0;
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
            ovf_o      <= 1'b0;
            rd_data_o  <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            cnt_q      <= cnt_d;
            frm_len_o  <= frm_len_d;
            err_o      <= err_d;
            err_code_o <= err_code_d;
            ovf_o      <= ovf_d;
            rd_data_o  <= ({1'b0, rd_addr_i} < MAX_LEN_A) ? pay_mem[rd_addr_i] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) pay_mem[idx_q[AW-1:0]] <= byte_i;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: drivers push expected events, a negedge monitor
// pops and compares every frame-valid change, error pulse, overrun pulse and read result.
module tb_uart_frame_parser;

    localparam int AW      = 4;
    localparam int TIMEOUT = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    byte_i;
    logic          byte_vld_i;
    logic          frm_valid_o;
    logic [AW:0]   frm_len_o;
    logic          frm_ack_i;
    logic [AW-1:0] rd_addr_i;
    logic [7:0]    rd_data_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic          ovf_o;
    logic [2:0]    dbg_state;

    uart_frame_parser #(.SOF(8'hA5), .MAX_LEN(16), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_vld_i(byte_vld_i),
        .frm_valid_o(frm_valid_o), .frm_len_o(frm_len_o), .frm_ack_i(frm_ack_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .err_o(err_o),
        .err_code_o(err_code_o), .ovf_o(ovf_o), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [1:0]    err_q[$];
    logic [0:0]    ovf_q[$];
    logic [AW+1:0] frm_q[$];   // {frm_valid_o, frm_len_o} after each valid transition
    logic [7:0]    rd_q[$];
    logic [7:0]    seq[$];
    logic          rd_req = 1'b0;
    logic          rd_chk = 1'b0;
    logic          prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_chk <= rd_req;

    always @(negedge clk) begin
        if (err_o) begin
            if (err_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL err_unexpected: got err_o=1 code %0b, expected no error", err_code_o);
            end else check("err_code", 32'(err_code_o), 32'(err_q.pop_front()));
        end
        if (ovf_o) begin
            n_vec++;
            if (ovf_q.size() == 0) begin
                n_err++;
                $display("FAIL ovf_unexpected: got ovf_o=1, expected no overrun");
            end else void'(ovf_q.pop_front());
        end
        if (frm_valid_o !== prev_valid) begin
            if (frm_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL frm_unexpected: got valid=%0b len=%0d, expected no change", frm_valid_o, frm_len_o);
            end else check("frm_valid_len", 32'({frm_valid_o, frm_len_o}), 32'(frm_q.pop_front()));
            prev_valid = frm_valid_o;
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_unexpected: got %0h, expected no read", rd_data_o);
            end else check("rd_data", 32'(rd_data_o), 32'(rd_q.pop_front()));
        end
    end

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    task automatic send_byte(input logic [7:0] b);
        byte_i = b; byte_vld_i = 1'b1;
        @(posedge clk); #1;
        byte_vld_i = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [7:0] exp);
        rd_addr_i = a; rd_req = 1'b1;
        rd_q.push_back(exp);
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic ack(input logic with_byte, input logic [7:0] b, input logic [AW:0] len);
        frm_ack_i = 1'b1;
        if (with_byte) begin
            byte_i = b; byte_vld_i = 1'b1;
            ovf_q.push_back(1'b1);
        end
        frm_q.push_back({1'b0, len});
        @(posedge clk); #1;
        frm_ack_i = 1'b0; byte_vld_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_frm_valid"}, 32'(frm_valid_o), 32'd0);
        check({tag, "_frm_len"},   32'(frm_len_o),   32'd0);
        check({tag, "_rd_data"},   32'(rd_data_o),   32'd0);
        check({tag, "_err"},       32'(err_o),       32'd0);
        check({tag, "_err_code"},  32'(err_code_o),  32'd0);
        check({tag, "_ovf"},       32'(ovf_o),       32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; byte_i = 8'h00; byte_vld_i = 1'b0; frm_ack_i = 1'b0; rd_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Good frame, then overrun while held, then ack with a byte on the same cycle.
        frm_q.push_back({1'b1, 5'd3});
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_seq();
        read(0, 8'h11); read(1, 8'h22); read(2, 8'h33);
        ovf_q.push_back(1'b1);
        send_byte(8'h77);
        read(0, 8'h11); read(1, 8'h22); read(2, 8'h33);
        ack(1'b1, 8'hA5, 5'd3);
        frm_ack_i = 1'b1; idle(1); frm_ack_i = 1'b0;   // ack in IDLE is ignored

        // Bad checksum: expected FD, sent 00.
        err_q.push_back(2'b10);
        seq = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        send_seq();
        idle(2);
        check("badchk_frm_valid", 32'(frm_valid_o), 32'd0);

        // Bad LEN 00 and 11, then a stray byte in IDLE.
        err_q.push_back(2'b01);
        seq = '{8'hA5, 8'h00};
        send_seq();
        err_q.push_back(2'b01);
        seq = '{8'hA5, 8'h11, 8'h5A};
        send_seq();
        idle(3);
        check("badlen_code_held", 32'(err_code_o), 32'd1);

        // Maximum length frame: payload 00..0F, checksum 10 ^ 00 ^ .. ^ 0F = 10.
        frm_q.push_back({1'b1, 5'd16});
        seq = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) seq.push_back(8'(i));
        seq.push_back(8'h10);
        send_seq();
        read(0, 8'h00); read(15, 8'h0F); read(7, 8'h07);
        ack(1'b0, 8'h00, 5'd16);

        // SOF value as payload data: checksum 02 ^ A5 ^ A5 = 02.
        frm_q.push_back({1'b1, 5'd2});
        seq = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
        send_seq();
        read(0, 8'hA5); read(1, 8'hA5);
        ack(1'b0, 8'h00, 5'd2);

        // Timeout mid-payload.
        err_q.push_back(2'b11);
        seq = '{8'hA5, 8'h02, 8'hAA};
        send_seq();
        idle(TIMEOUT + 5);

        // Bytes landing exactly on the terminal count cycle are accepted; checksum 02^11^22 = 31.
        frm_q.push_back({1'b1, 5'd2});
        send_byte(8'hA5); send_byte(8'h02);
        idle(TIMEOUT - 1); send_byte(8'h11);
        idle(TIMEOUT - 1); send_byte(8'h22);
        idle(TIMEOUT - 1); send_byte(8'h31);
        read(0, 8'h11); read(1, 8'h22);
        ack(1'b0, 8'h00, 5'd2);

        // Reset mid-frame abandons it silently.
        seq = '{8'hA5, 8'h04, 8'h01};
        send_seq();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        frm_q.push_back({1'b1, 5'd1});
        seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_seq();
        read(0, 8'h5A);
        ack(1'b0, 8'h00, 5'd1);

        idle(5);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        check("ovf_q_drained", 32'(ovf_q.size()), 32'd0);
        check("frm_q_drained", 32'(frm_q.size()), 32'd0);
        check("rd_q_drained",  32'(rd_q.size()),  32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
